// File: rtl/fpu_defs_fmac.sv
// Shared definitions for the FMAC carry-propagate adder stage: mantissa width,
// derived vector widths and the stage-A register layout.
package fpu_defs_fmac;

    // Mantissa width of the single-precision datapath.
    localparam int unsigned C_MANT = 24;

    // Width of the sum/carry vectors leaving the reduction tree.
    function automatic int unsigned cpa_width(input int unsigned mant);
        return 2 * mant + 3;
    endfunction

    // Width of the low slice added in the first pipeline stage.
    function automatic int unsigned cpa_low(input int unsigned mant);
        return mant + 1;
    endfunction

    // Width of the high slice added in the second pipeline stage.
    function automatic int unsigned cpa_high(input int unsigned mant);
        return cpa_width(mant) - cpa_low(mant);
    endfunction

    localparam int unsigned C_W = cpa_width(C_MANT);
    localparam int unsigned C_L = cpa_low(C_MANT);
    localparam int unsigned C_H = cpa_high(C_MANT);

    // Everything stage A hands to stage B: the finished low sum, the carry
    // leaving it, the untouched high operand slices and the flags.
    typedef struct packed {
        logic [C_H-1:0] sum_hi;
        logic [C_H-1:0] carry_hi;
        logic [C_L-1:0] sum_lo;
        logic           carry;
        logic           msb_cor;
        logic           sticky;
    } cpa_stage_t;

endpackage

// File: rtl/cpa_pipe_ctrl.sv
// Handshake control for the two-stage carry-propagate adder: stage valid
// bits, per-stage load enables and the flush (kill) path.
module cpa_pipe_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid,
    input  logic dn_ready,
    input  logic kill,
    output logic up_ready,
    output logic dn_valid,
    output logic a_load,
    output logic b_load
);

    logic a_valid;
    logic b_valid;
    logic b_advance;
    logic a_free;

    // Stage B advances when empty or drained downstream; stage A when empty
    // or when B takes its contents. Kill blocks every movement.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
        b_advance = 1'b0;
        a_free    = 1'b0;
        if (!kill) begin
            b_advance = !b_valid || dn_ready;
            a_free    = !a_valid || b_advance;
        end
    end

    assign up_ready = a_free;
    assign a_load   = a_free && up_valid;
    assign b_load   = b_advance && a_valid;
    assign dn_valid = b_valid;

    // Stage occupancy; kill empties both stages on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else if (kill) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (b_advance) b_valid <= a_valid;
            if (a_free)    a_valid <= up_valid;
        end
    end

endmodule

// File: rtl/cpa_pipe.sv
// Two-stage carry-propagate adder closing the FMAC multiplier: adds the
// reduction tree's sum and shifted carry vectors, splitting the add at bit L.
// Optional feature macro: FMAC_CPA_STICKY_EN (registered sticky of the low
// C_MANT product bits); when undefined Sticky_SO is constant 0.
// The stage-A register layout comes from fpu_defs_fmac and is sized by the
// package C_MANT, so overriding C_MANT must go together with the package.
module cpa_pipe #(
    parameter int unsigned C_MANT = fpu_defs_fmac::C_MANT
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,
    input  logic                       Valid_SI,
    output logic                       Ready_SO,
    input  logic [2*C_MANT+3-1:0]      Pp_sum_DI,
    input  logic [2*C_MANT+3-1:0]      Pp_carry_DI,
    input  logic                       MSB_cor_DI,
    input  logic                       Kill_SI,
    output logic                       Valid_SO,
    input  logic                       Ready_SI,
    output logic [2*C_MANT+3-1:0]      Product_DO,
    output logic                       Sticky_SO
);

    import fpu_defs_fmac::*;

    localparam int unsigned W = cpa_width(C_MANT);
    localparam int unsigned L = cpa_low(C_MANT);
    localparam int unsigned H = cpa_high(C_MANT);

    logic a_load;
    logic b_load;

    cpa_pipe_ctrl u_ctrl (
        .clk      (Clk_CI),
        .rst_n    (Rst_RBI),
        .up_valid (Valid_SI),
        .dn_ready (Ready_SI),
        .kill     (Kill_SI),
        .up_ready (Ready_SO),
        .dn_valid (Valid_SO),
        .a_load   (a_load),
        .b_load   (b_load)
    );

    logic [W-1:0] carry_sh;
    logic [L:0]   low_full;
    cpa_stage_t   stage_a_d;
    cpa_stage_t   stage_a_q;
    logic [H-1:0] hi_sum;
    logic [W-1:0] product_d;

    // Stage A: add the low slices and capture the carry crossing the split.
    always_comb begin
        carry_sh           = Pp_carry_DI << 1;
        low_full           = {1'b0, Pp_sum_DI[L-1:0]} + {1'b0, carry_sh[L-1:0]};
        stage_a_d          = '0;
        stage_a_d.sum_lo   = low_full[L-1:0];
        stage_a_d.carry    = low_full[L];
        stage_a_d.sum_hi   = Pp_sum_DI[W-1:L];
        stage_a_d.carry_hi = carry_sh[W-1:L];
        stage_a_d.msb_cor  = MSB_cor_DI;
`ifdef FMAC_CPA_STICKY_EN
        stage_a_d.sticky   = |low_full[C_MANT-1:0];
`endif
    end

    // Stage A operand register, written only when the stage accepts.
    always_ff @(posedge Clk_CI) begin
        // NOTE: pure data registers carry no reset; the stage valid bit decides whether they mean anything.
        if (a_load) stage_a_q <= stage_a_d;
    end

    // Stage B: finish the high half (carry-out of bit W-1 drops) and apply the MSB correction.
    always_comb begin
        hi_sum            = stage_a_q.sum_hi + stage_a_q.carry_hi + H'(stage_a_q.carry);
        product_d         = {hi_sum, stage_a_q.sum_lo};
        product_d[W-1]    = product_d[W-1] ^ stage_a_q.msb_cor;
    end

    // Stage B output register; holds its value while downstream stalls.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            Product_DO <= '0;
        end else if (b_load) begin
            Product_DO <= product_d;
        end
    end

`ifdef FMAC_CPA_STICKY_EN
    // Sticky travels with the product through stage B.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            Sticky_SO <= 1'b0;
        end else if (b_load) begin
            Sticky_SO <= stage_a_q.sticky;
        end
    end
`else
    // The sticky field exists in the shared layout but is never read here.
    logic sticky_unused;
    assign sticky_unused = stage_a_q.sticky;
    assign Sticky_SO     = 1'b0;
`endif

endmodule

// File: tb/tb_cpa_pipe.sv
// Scoreboard bench for cpa_pipe: the driver issues directed and random
// operands, the monitor pushes reference results on input handshakes and
// pops/compares on output handshakes. Honours FMAC_CPA_STICKY_EN.
module tb_cpa_pipe;

    import fpu_defs_fmac::*;

    localparam int unsigned W  = cpa_width(C_MANT);
    localparam int unsigned MB = C_MANT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Valid_SI = 1'b0;
    logic         Ready_SO;
    logic [W-1:0] Pp_sum_DI = '0;
    logic [W-1:0] Pp_carry_DI = '0;
    logic         MSB_cor_DI = 1'b0;
    logic         Kill_SI = 1'b0;
    logic         Valid_SO;
    logic         Ready_SI = 1'b0;
    logic [W-1:0] Product_DO;
    logic         Sticky_SO;

    cpa_pipe #(.C_MANT(C_MANT)) dut (
        .Clk_CI      (clk),
        .Rst_RBI     (rst_n),
        .Valid_SI    (Valid_SI),
        .Ready_SO    (Ready_SO),
        .Pp_sum_DI   (Pp_sum_DI),
        .Pp_carry_DI (Pp_carry_DI),
        .MSB_cor_DI  (MSB_cor_DI),
        .Kill_SI     (Kill_SI),
        .Valid_SO    (Valid_SO),
        .Ready_SI    (Ready_SI),
        .Product_DO  (Product_DO),
        .Sticky_SO   (Sticky_SO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] prod;
        logic         sticky;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   lat_mode = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: whole-width modular addition of sum and doubled carry.
    function automatic logic [W-1:0] ref_prod(input logic [W-1:0] s, input logic [W-1:0] c, input logic m);
        logic [W:0]   full;
        logic [W-1:0] r;
        full = {1'b0, s} + ({1'b0, c} << 1);
        r = full[W-1:0];
        if (m) r[W-1] = ~r[W-1];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [63:0] r;
        case ($urandom_range(0, 7))
            0:       r = '1;
            1:       r = '0;
            default: r = {$urandom, $urandom};
        endcase
        return r[W-1:0];
    endfunction

    // Monitor / scoreboard, sampling mid-cycle after the driver has settled.
    bit           hold_pend = 1'b0;
    logic [W-1:0] hold_val = '0;
    bit           head_seen = 1'b0;
    bit           kill_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                sb.delete();
                hold_pend = 1'b0;
                head_seen = 1'b0;
                kill_prev = 1'b0;
            end else begin
                if (kill_prev) check("kill_flush_valid", Valid_SO, 0);
                if (hold_pend) begin
                    check("hold_valid", Valid_SO, 1);
                    check("hold_data", Product_DO, hold_val);
                    hold_pend = 1'b0;
                end
                kill_prev = Kill_SI;
                if (Kill_SI) begin
                    check("kill_ready_low", Ready_SO, 0);
                    sb.delete();
                    head_seen = 1'b0;
                end else begin
                    if (Valid_SO) begin
                        if (sb.size() == 0) begin
                            check("spurious_output", Valid_SO, 0);
                        end else begin
                            if (!head_seen && sb[0].lat) check("latency", cyc - sb[0].acc, 2);
                            head_seen = 1'b1;
                            if (Ready_SI) begin
                                check("product", Product_DO, sb[0].prod);
                                check("sticky", Sticky_SO, sb[0].sticky);
                                void'(sb.pop_front());
                                head_seen = 1'b0;
                            end else begin
                                hold_pend = 1'b1;
                                hold_val  = Product_DO;
                            end
                        end
                    end
                    if (Valid_SI && Ready_SO) begin
                        logic [W-1:0] p;
                        logic         st;
                        p = ref_prod(Pp_sum_DI, Pp_carry_DI, MSB_cor_DI);
`ifdef FMAC_CPA_STICKY_EN
                        st = |p[MB-1:0];
`else
                        st = 1'b0;
`endif
                        sb.push_back('{p, st, cyc, lat_mode});
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [W-1:0] s, input logic [W-1:0] c,
                         input bit m, input bit rdy, input bit k);
        @(negedge clk);
        Valid_SI    = v;
        Pp_sum_DI   = s;
        Pp_carry_DI = c;
        MSB_cor_DI  = m;
        Ready_SI    = rdy;
        Kill_SI     = k;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] bs[4];
    logic [W-1:0] bc[4];
    int           n;
    int           n_acc;
    bit           k;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", Valid_SO, 0);
        check("reset_product", Product_DO, 0);
        check("reset_sticky", Sticky_SO, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_ready", Ready_SO, 1);

        // Directed arithmetic with exact latency, then a back-to-back burst.
        lat_mode = 1'b1;
        drive(1'b1, W'(1), W'(1), 1'b0, 1'b1, 1'b0);
        drive(1'b1, '1, W'(1), 1'b0, 1'b1, 1'b0);
        drive(1'b1, '1, W'(1), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            #1;
            check("burst_ready", Ready_SO, 1);
        end
        idle(4);
        lat_mode = 1'b0;

        // Backpressure: downstream stalls five cycles while four inputs wait.
        for (int i = 0; i < 4; i++) begin
            bs[i] = rand_w();
            bc[i] = rand_w();
        end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            drive(n < 4, bs[n % 4], bc[n % 4], 1'b0, 1'b0, 1'b0);
            #1;
            if (n >= 2) check("bp_ready_low", Ready_SO, 0);
            if (Valid_SI && Ready_SO) n++;
        end
        check("bp_accepted_in_stall", n, 2);
        for (int i = 0; i < 12 && n < 4; i++) begin
            drive(1'b1, bs[n], bc[n], 1'b0, 1'b1, 1'b0);
            #1;
            if (Valid_SI && Ready_SO) n++;
        end
        check("bp_all_accepted", n, 4);
        idle(5);

        // Kill with two operations in flight, then resume at once.
        drive(1'b1, rand_w(), rand_w(), 1'b0, 1'b1, 1'b0);
        drive(1'b1, rand_w(), rand_w(), 1'b1, 1'b1, 1'b0);
        drive(1'b1, rand_w(), rand_w(), 1'b0, 1'b0, 1'b1);
        #1;
        check("kill_ready", Ready_SO, 0);
        drive(1'b1, rand_w(), rand_w(), 1'b0, 1'b1, 1'b0);
        #1;
        check("resume_ready", Ready_SO, 1);
        idle(5);

        // Asynchronous reset during a stall.
        drive(1'b1, '1, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, '1, W'(5), 1'b0, 1'b0, 1'b0);
        drive(1'b1, rand_w(), rand_w(), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        Valid_SI = 1'b0;
        #1;
        check("async_reset_valid", Valid_SO, 0);
        check("async_reset_product", Product_DO, 0);
        check("async_reset_sticky", Sticky_SO, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", Ready_SO, 1);
        idle(3);

        // Random operands with random backpressure and rare kills.
        n_acc = 0;
        for (int i = 0; i < 40000 && n_acc < 10000; i++) begin
            k = ($urandom_range(0, 399) == 0);
            drive($urandom_range(0, 3) != 0, rand_w(), rand_w(), 1'($urandom_range(0, 1)),
                  k ? 1'b0 : ($urandom_range(0, 2) != 0), k);
            #1;
            if (Valid_SI && Ready_SO) n_acc++;
        end
        check("random_accepted", n_acc, 10000);

        // Drain, bounded.
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(1);
        check("drain_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpa_pipe.md
CPA_PIPE -- requirements
Module: cpa_pipe

Interface
REQ-001 Parameter C_MANT, default fpu_defs_fmac::C_MANT, mantissa width; W = 2*C_MANT+3, L = C_MANT+1 (low split), H = W-L.
REQ-002 Clk_CI  in  1  clock, rising edge.
REQ-003 Rst_RBI  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Valid_SI  in  1  upstream operands valid.
REQ-005 Ready_SO  out  1  stage can accept operands.
REQ-006 Pp_sum_DI  in  W  sum vector from the partial-product reduction tree.
REQ-007 Pp_carry_DI  in  W  carry vector, unshifted.
REQ-008 MSB_cor_DI  in  1  MSB correction flag from the reduction tree.
REQ-009 Kill_SI  in  1  flush all in-flight operations.
REQ-010 Valid_SO  out  1  result valid.
REQ-011 Ready_SI  in  1  downstream accepts result.
REQ-012 Product_DO  out  W  final carry-propagated product.
REQ-013 Sticky_SO  out  1  OR of Product_DO[C_MANT-1:0] (see Configuration).

Function
REQ-014 Arithmetic: P = Pp_sum + {Pp_carry[W-2:0],1'b0} modulo 2^W; Product_DO = P with bit W-1 inverted when MSB_cor set.
REQ-015 Stage A (cycle of acceptance): low sum P[L-1:0] and carry-out cL = bit L of Pp_sum[L-1:0]+shifted carry[L-1:0]; registers low sum, cL, high operand slices, MSB_cor.
REQ-016 Stage B: high sum = high slices + cL, MSB correction applied; registers full Product_DO.
REQ-017 Latency exactly 2 cycles from accepted handshake to Valid_SO with no backpressure; throughput 1/cycle.
REQ-018 Handshake: transfer on Valid&&Ready each side; Valid_SO and Product_DO hold stable while Valid_SO && !Ready_SI.
REQ-019 Stage B loads when empty or Ready_SI; stage A loads when empty or stage B loads; Ready_SO = !A_valid || B_load (combinational from Ready_SI).
REQ-020 Full pipeline with Ready_SI low: Ready_SO low, no data lost or duplicated.
REQ-021 Simultaneous output transfer and input acceptance with both stages full: both advance in the same cycle.
REQ-022 Kill_SI high: both stage valid bits cleared next edge; input presented that cycle not accepted (Ready_SO forced low); Kill has priority over all.
REQ-023 Data registers load only on stage load enable; not reset (valid bits gate them).
REQ-024 Wrap-around: carry-out of bit W-1 discarded.

Reset
REQ-025 Asynchronous assert on Rst_RBI low: both stage valid bits 0, Valid_SO 0, Product_DO 0, Sticky_SO 0.
REQ-026 Reset mid-operation discards in-flight data; Ready_SO = 1 first cycle after deassertion.

Configuration
REQ-027 Macro FMAC_CPA_STICKY_EN defined: Sticky_SO registered in stage B alongside Product_DO, computed from low sum bits [C_MANT-1:0] of stage A, stable under backpressure.
REQ-028 Macro undefined: Sticky_SO tied 0, no sticky logic synthesized; all other behaviour identical.

Structure
REQ-029 W, L, H width functions and a cpa_stage_t struct (low sum, carry, high slices, MSB_cor, sticky) belong in fpu_defs_fmac.
REQ-030 One sub-module, cpa_pipe_ctrl, holds valid bits, load enables and Kill logic; datapath stays in cpa_pipe.

Verification
REQ-031 C_MANT=24: sum=0x1, carry=0x1, MSB_cor=0 -> Product_DO=0x3 exactly 2 cycles after acceptance.
REQ-032 sum=all ones, carry=0x1 -> Product_DO=0x1 (wrap, cross-split carry propagated); same with MSB_cor=1 -> bit W-1 set.
REQ-033 Ready_SI low 5 cycles, 4 back-to-back inputs -> Ready_SO low after 2 accepted, outputs in order, none dropped.
REQ-034 Kill_SI pulse with 2 in flight -> Valid_SO 0 next cycle, Ready_SO 0 during Kill, accepted stream resumes next cycle.
REQ-035 Rst_RBI asserted asynchronously mid-stall -> outputs 0 immediately, Ready_SO 1 after release.
REQ-036 Random 10k operands vs. reference model with random backpressure, both macro settings; Sticky_SO checked when enabled, 0 otherwise.
